// File: rtl/tpu_result_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_result_streamer_if
//  Purpose  : Bundles the TPU result inputs, the overrun control and the
//             byte-stream valid/ready port of tpu_result_streamer.
//  Modports : master - streamer side (drives tx_*, busy, overrun)
//             slave  - TPU/sink side (drives done, result_*, clear_overrun,
//                      tx_ready)
//  Signals  : done, result_0..3 [ACC_WIDTH], clear_overrun,
//             tx_data[7:0], tx_valid, tx_ready, busy, overrun
//  Revision : 1.0 - initial release
// ============================================================================
interface tpu_result_streamer_if #(
  parameter int ACC_WIDTH = 32
);
  logic                 done;
  logic [ACC_WIDTH-1:0] result_0;
  logic [ACC_WIDTH-1:0] result_1;
  logic [ACC_WIDTH-1:0] result_2;
  logic [ACC_WIDTH-1:0] result_3;
  logic                 clear_overrun;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  done, result_0, result_1, result_2, result_3, clear_overrun, tx_ready,
    output tx_data, tx_valid, busy, overrun
  );

  modport slave (
    output done, result_0, result_1, result_2, result_3, clear_overrun, tx_ready,
    input  tx_data, tx_valid, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/tpu_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_result_streamer
//  Purpose  : Snapshots the four TPU result words on a rising edge of done
//             and serialises them as a framed byte stream:
//               A5, NUM_RESULTS, result_0..3 little-endian, checksum.
//             Checksum is XOR over CNT+DATA bytes, or CRC-8 (poly 0x07,
//             init 0, MSB-first) when TPU_STREAM_CRC8_EN is defined.
//  Ports    : clk  - system clock
//             rst  - synchronous reset, active-high
//             bus  - tpu_result_streamer_if.master (results in, byte
//                    stream out, busy / sticky overrun status)
//  Config   : `define TPU_STREAM_CRC8_EN selects the CRC-8 checksum.
//  Revision : 1.0 - initial release
// ============================================================================
module tpu_result_streamer #(
  parameter int ACC_WIDTH   = 32,   // multiple of 8
  parameter int NUM_RESULTS = 4     // tied to the four result_* signals
) (
  input  wire logic              clk,
  input  wire logic              rst,
  tpu_result_streamer_if.master  bus
);

  localparam int              BYTES_PER_WORD = ACC_WIDTH / 8;
  localparam int              DATA_BYTES     = NUM_RESULTS * BYTES_PER_WORD;
  localparam int              IDX_W          = $clog2(DATA_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BYTES - 1);
  localparam logic [7:0]      HDR_BYTE       = 8'hA5;
  localparam logic [7:0]      CNT_BYTE       = 8'(NUM_RESULTS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CNT  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            r_done_q;
  logic [NUM_RESULTS*ACC_WIDTH-1:0] r_snap;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic [IDX_W-1:0]                w_idx_inc;
  logic [7:0]                      r_tx_data;
  logic [7:0]                      w_tx_data_nxt;
  logic                            r_tx_valid;
  logic                            w_tx_valid_nxt;
  logic [7:0]                      r_csum;
  logic [7:0]                      w_csum_nxt;
  logic [7:0]                      w_csum_upd;
  logic                            r_overrun;
  logic                            w_done_rise;
  logic                            w_accept;
  logic                            w_capture;
  logic [7:0]                      w_byte_first;
  logic [7:0]                      w_byte_next;

  // One checksum step over the byte currently on tx_data.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef TPU_STREAM_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc ^ b;
`endif
  endfunction

  assign w_done_rise  = bus.done & ~r_done_q;
  assign w_accept     = r_tx_valid & bus.tx_ready;
  assign w_idx_inc    = r_idx + 1'b1;
  // The CSUM byte must include the last DATA byte, so the running checksum
  // is folded with the byte being accepted right now.
  assign w_csum_upd   = csum_step(r_csum, r_tx_data);
  assign w_byte_first = r_snap[7:0];
  assign w_byte_next  = r_snap[{w_idx_inc, 3'b000} +: 8];

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_csum_nxt     = r_csum;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_done_rise) begin
          w_capture      = 1'b1;
          w_state_nxt    = S_HDR;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = HDR_BYTE;
          w_csum_nxt     = 8'h00;
          w_idx_nxt      = '0;
        end
      end
      S_HDR: begin
        if (w_accept) begin
          w_state_nxt   = S_CNT;
          w_tx_data_nxt = CNT_BYTE;
        end
      end
      S_CNT: begin
        if (w_accept) begin
          w_state_nxt   = S_DATA;
          w_csum_nxt    = w_csum_upd;
          w_idx_nxt     = '0;
          w_tx_data_nxt = w_byte_first;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_csum_nxt = w_csum_upd;
          if (r_idx == IDX_LAST) begin
            w_state_nxt   = S_CSUM;
            w_tx_data_nxt = w_csum_upd;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_tx_data_nxt = w_byte_next;
          end
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          w_state_nxt    = S_IDLE;
          w_tx_valid_nxt = 1'b0;
          w_tx_data_nxt  = 8'h00;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_done_q   <= 1'b0;
      r_snap     <= '0;
      r_idx      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_csum     <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done_q   <= bus.done;
      r_idx      <= w_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_csum     <= w_csum_nxt;
      if (w_capture) begin
        r_snap <= {bus.result_3, bus.result_2, bus.result_1, bus.result_0};
      end
      // A new set event takes priority over a simultaneous clear.
      if (w_done_rise && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (bus.clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire
